// File: rtl/game_flow_ctrl.sv
// Game-flow controller: level/lives tracking, timed interstitial screens, switch-combo restart.
// Optional lives counter and LIFE_LOST state are enabled by defining GAME_FLOW_LIVES_EN.
module game_flow_ctrl #(
    parameter int NUM_LEVELS    = 9,
    parameter int LIVES         = 3,
    parameter int SCREEN_CYCLES = 50_000_000,
    parameter int NUM_SW        = 4,
    localparam int LVL_W = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1,
    localparam int LIV_W = $clog2(LIVES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              level_complete,
    input  logic              player_hit,
    input  logic [NUM_SW-1:0] switches,
    output logic [2:0]        state,
    output logic [LVL_W-1:0]  level,
    output logic [LIV_W-1:0]  lives,
    output logic              level_start
);

    localparam int TMR_W = (SCREEN_CYCLES > 2) ? $clog2(SCREEN_CYCLES) : 1;
    localparam logic [LVL_W-1:0] LAST_LVL  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(SCREEN_CYCLES - 1);
    localparam logic [LIV_W-1:0] LIV_INIT  = LIV_W'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_PLAY        = 3'd1,
        S_LEVEL_CLEAR = 3'd2,
        S_LIFE_LOST   = 3'd3,
        S_GAME_OVER   = 3'd4,
        S_WIN         = 3'd5
    } state_t;

    state_t            state_q, state_nxt;
    logic [LVL_W-1:0]  level_q, level_nxt;
    logic [TMR_W-1:0]  timer_q, timer_nxt;
    logic              level_start_nxt;
    logic [NUM_SW-1:0] sw_s1, sw_s2;
    logic              combo, combo_q, restart;

    // Two-flop synchroniser plus a history flop so a held combo restarts only once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            combo_q <= 1'b0;
        end else begin
            sw_s1   <= switches;
            sw_s2   <= sw_s1;
            combo_q <= combo;
        end
    end

    assign combo   = &sw_s2;
    assign restart = combo & ~combo_q;

`ifdef GAME_FLOW_LIVES_EN
    logic [LIV_W-1:0] lives_q, lives_nxt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            level_q     <= '0;
            timer_q     <= '0;
            level_start <= 1'b0;
`ifdef GAME_FLOW_LIVES_EN
            lives_q     <= LIV_INIT;
`endif
        end else begin
            state_q     <= state_nxt;
            level_q     <= level_nxt;
            timer_q     <= timer_nxt;
            level_start <= level_start_nxt;
`ifdef GAME_FLOW_LIVES_EN
            lives_q     <= lives_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state_q;
        level_nxt = level_q;
        timer_nxt = timer_q;
`ifdef GAME_FLOW_LIVES_EN
        lives_nxt = lives_q;
`endif
        if (restart) begin
            state_nxt = S_IDLE;
            level_nxt = '0;
            timer_nxt = '0;
`ifdef GAME_FLOW_LIVES_EN
            lives_nxt = LIV_INIT;
`endif
        end else begin
            unique case (state_q)
                S_IDLE, S_GAME_OVER, S_WIN: begin
                    if (start) begin
                        state_nxt = S_PLAY;
                        level_nxt = '0;
`ifdef GAME_FLOW_LIVES_EN
                        lives_nxt = LIV_INIT;
`endif
                    end
                end
                S_PLAY: begin
                    if (level_complete) begin
                        if (level_q == LAST_LVL) begin
                            state_nxt = S_WIN;
                        end else begin
                            state_nxt = S_LEVEL_CLEAR;
                            timer_nxt = TMR_LOAD;
                        end
                    end else if (player_hit) begin
`ifdef GAME_FLOW_LIVES_EN
                        if (lives_q > LIV_W'(1)) begin
                            state_nxt = S_LIFE_LOST;
                            lives_nxt = lives_q - 1'b1;
                            timer_nxt = TMR_LOAD;
                        end else begin
                            state_nxt = S_GAME_OVER;
                            lives_nxt = '0;
                        end
`else
                        state_nxt = S_GAME_OVER;
`endif
                    end
                end
                S_LEVEL_CLEAR: begin
                    if (timer_q == '0) begin
                        state_nxt = S_PLAY;
                        if (level_q != LAST_LVL) level_nxt = level_q + 1'b1;
                    end else begin
                        timer_nxt = timer_q - 1'b1;
                    end
                end
                S_LIFE_LOST: begin
                    if (timer_q == '0) state_nxt = S_PLAY;
                    else               timer_nxt = timer_q - 1'b1;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Pulse is registered, so it lands on the first cycle PLAY is visible.
    always_comb begin
        level_start_nxt = (state_nxt == S_PLAY) && (state_q != S_PLAY);
    end

    assign state = state_q;
    assign level = level_q;
`ifdef GAME_FLOW_LIVES_EN
    assign lives = lives_q;
`else
    assign lives = LIV_W'(1);
`endif

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised game-flow controller: tracks the current level, remaining lives and the top-level game state, and inserts timed interstitial screens between levels and after lost lives. It sits between the gameplay logic, which raises `level_complete` and `player_hit`, and the display/sprite logic, which consumes `state`, `level` and `level_start`. Board switches give a synchronised all-switches-high restart combo.

## Interface
- `NUM_LEVELS`, 9: levels per game (≥2); level index 0..NUM_LEVELS-1.
- `LIVES`, 3: lives at game start (≥1).
- `SCREEN_CYCLES`, 50_000_000: dwell of LEVEL_CLEAR / LIFE_LOST screens in clk cycles (≥2).
- `NUM_SW`, 4: number of board switches in the restart combo.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: synchronous level-sensitive start request.
- `level_complete` in 1: gameplay reports current level cleared (sampled in PLAY only).
- `player_hit` in 1: gameplay reports player death (sampled in PLAY only).
- `switches` in NUM_SW: raw asynchronous board switches.
- `state` out 3: 0 IDLE, 1 PLAY, 2 LEVEL_CLEAR, 3 LIFE_LOST, 4 GAME_OVER, 5 WIN.
- `level` out LVL_W = max(1, $clog2(NUM_LEVELS)): current level index.
- `lives` out LIV_W = $clog2(LIVES+1): remaining lives.
- `level_start` out 1: one-cycle pulse on the first PLAY cycle of every (re)entered level.

## Operation
- Reset (`reset_n`=0): state IDLE, level 0, lives LIVES, level_start 0, timer 0, synchroniser flops 0.
- `switches` pass through a 2-flop synchroniser; `combo` = AND of synchronised bits; `restart` = rising edge of `combo` (one extra history flop).
- `restart` has top priority in every state: next state IDLE, level 0, lives LIVES, timer 0, no level_start.
- IDLE: `start`=1 → PLAY, level 0, lives LIVES, level_start pulse.
- PLAY: `level_complete` wins over simultaneous `player_hit`.
  - level_complete at level NUM_LEVELS-1 → WIN (level held).
  - level_complete otherwise → LEVEL_CLEAR, timer loaded SCREEN_CYCLES-1.
  - player_hit with lives>1 → LIFE_LOST, lives-1, timer loaded SCREEN_CYCLES-1.
  - player_hit with lives==1 → GAME_OVER, lives 0.
- LEVEL_CLEAR: timer decrements; at timer==0 → PLAY, level+1, level_start pulse.
- LIFE_LOST: timer decrements; at timer==0 → PLAY, level unchanged, level_start pulse.
- GAME_OVER, WIN: hold; `start`=1 → PLAY as new game (level 0, lives LIVES, level_start pulse).
- `level_complete`/`player_hit` ignored outside PLAY; `start` ignored in PLAY, LEVEL_CLEAR, LIFE_LOST.
- Level never exceeds NUM_LEVELS-1; lives never underflow.

## Timing
- All outputs registered; state/level/lives update on the clk edge sampling the cause (1-cycle latency).
- level_start high exactly in the first cycle `state`==PLAY after entry; never two consecutive cycles.
- Interstitial dwell: exactly SCREEN_CYCLES cycles with `state`==LEVEL_CLEAR/LIFE_LOST.
- Switch-to-restart latency: 3 clk cycles after switch bits settle high (2 sync + edge register); holding the combo causes only one restart; releasing and re-asserting causes another.
- Restart on the same cycle as `start` in IDLE: restart wins, state stays IDLE.
- Async reset mid-interstitial clears timer immediately; no level_start after reset release.

## Configuration
- `GAME_FLOW_LIVES_EN` defined: lives counter and LIFE_LOST state as above.
- Undefined: no lives counter; `lives` tied to constant 1; any `player_hit` in PLAY → GAME_OVER; LIFE_LOST unreachable (encoding 3 reserved).

## Test plan
Params NUM_LEVELS=3, LIVES=2, SCREEN_CYCLES=4, NUM_SW=4, macro defined unless stated.
- Reset, start 1 cycle → state 1, level 0, lives 2, one level_start pulse.
- level_complete at level 0 → state 2 for exactly 4 cycles, then state 1, level 1, level_start pulse; repeat to level 2, level_complete → state 5, level 2.
- player_hit at level 1 → state 3, lives 1, 4 cycles later state 1, level 1, pulse; second hit → state 4, lives 0.
- level_complete and player_hit same cycle at level 0 → state 2, lives stays 2.
- switches to 4'b1111 in LEVEL_CLEAR, held 20 cycles → state 0 on third cycle, level 0, lives 2, exactly one restart; switches 4'b1110 has no effect.
- Macro undefined: single player_hit in PLAY → state 4, lives reads 1.
